// File: rtl/lfsr_axil_gen.sv
// lfsr_axil_gen
//   Fibonacci LFSR generator of LFSR_W bits. It streams its state on an
//   AXI-Stream master with full tready backpressure, and software configures
//   it over a 32-bit AXI-Lite slave.
//
//   Register map (byte address):
//     0x00 START  (WO)  bit0=1 starts a run when idle
//     0x04 STOP   (WO)  bit0=1 requests a stop
//     0x08 SEED   (RW)  seed, loaded at start (0 is replaced by 1)
//     0x0C TAPS   (RW)  feedback taps, loaded at start
//     0x10 COUNT  (RW)  burst length in words, 0 = free-run
//     0x14 STATUS (RO)  bit0 running, bit1 done (sticky), bit2 draining
//     0x18 STATE  (RO)  working LFSR state
//
// Ports:
//   aclk, aresetn         clock, synchronous active-low reset
//   lfsr_s_axi_*          AXI-Lite slave (5-bit address, 32-bit data)
//   lfsr_m_axis_*         AXI-Stream master (tdata zero-extended state, tlast at burst end)
module lfsr_axil_gen #(
  parameter int unsigned          LFSR_W   = 8,
  parameter logic [LFSR_W-1:0]    RST_TAPS = LFSR_W'(8'hB8),
  parameter logic [LFSR_W-1:0]    RST_SEED = LFSR_W'(1)
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [4:0]  lfsr_s_axi_awaddr,
  input  logic        lfsr_s_axi_awvalid,
  output logic        lfsr_s_axi_awready,
  input  logic [31:0] lfsr_s_axi_wdata,
  input  logic        lfsr_s_axi_wvalid,
  output logic        lfsr_s_axi_wready,
  output logic [1:0]  lfsr_s_axi_bresp,
  output logic        lfsr_s_axi_bvalid,
  input  logic        lfsr_s_axi_bready,
  input  logic [4:0]  lfsr_s_axi_araddr,
  input  logic        lfsr_s_axi_arvalid,
  output logic        lfsr_s_axi_arready,
  output logic [31:0] lfsr_s_axi_rdata,
  output logic [1:0]  lfsr_s_axi_rresp,
  output logic        lfsr_s_axi_rvalid,
  input  logic        lfsr_s_axi_rready,
  output logic [31:0] lfsr_m_axis_tdata,
  output logic        lfsr_m_axis_tvalid,
  input  logic        lfsr_m_axis_tready,
  output logic        lfsr_m_axis_tlast
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} fsm_e;

  localparam logic [4:0] A_START  = 5'h00;
  localparam logic [4:0] A_STOP   = 5'h04;
  localparam logic [4:0] A_SEED   = 5'h08;
  localparam logic [4:0] A_TAPS   = 5'h0C;
  localparam logic [4:0] A_COUNT  = 5'h10;
  localparam logic [4:0] A_STATUS = 5'h14;
  localparam logic [4:0] A_STATE  = 5'h18;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  fsm_e              fsm_q, fsm_d;
  logic [LFSR_W-1:0] seed_q, seed_d;
  logic [LFSR_W-1:0] taps_q, taps_d;
  logic [31:0]       count_q, count_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] taps_w_q, taps_w_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              busy;
  logic              last;
  logic              beat;
  logic              wr_accept;
  logic              rd_accept;
  logic              fb;
  logic [LFSR_W-1:0] lfsr_next;

  always_comb begin
    busy      = (fsm_q != ST_IDLE);
    last      = (len_q != '0) && (cnt_q == len_q - 32'd1);
    beat      = busy && lfsr_m_axis_tready;
    fb        = ^(lfsr_q & taps_w_q);
    lfsr_next = {lfsr_q[LFSR_W-2:0], fb};
    wr_accept = lfsr_s_axi_awvalid && lfsr_s_axi_wvalid && !bvalid_q && !awready_q;
    rd_accept = lfsr_s_axi_arvalid && !rvalid_q && !arready_q;
  end

  always_comb begin
    fsm_d     = fsm_q;
    seed_d    = seed_q;
    taps_d    = taps_q;
    count_d   = count_q;
    lfsr_d    = lfsr_q;
    taps_w_d  = taps_w_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    awready_d = wr_accept;
    wready_d  = wr_accept;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    arready_d = rd_accept;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    // Stream beat. A burst-end beat finishes the run from RUN or DRAIN;
    // any other beat in DRAIN is the final one.
    if (beat) begin
      lfsr_d = lfsr_next;
      cnt_d  = cnt_q + 32'd1;
      if (last) begin
        fsm_d  = ST_IDLE;
        done_d = 1'b1;
      end else if (fsm_q == ST_DRAIN) begin
        fsm_d = ST_IDLE;
      end
    end

    if (bvalid_q && lfsr_s_axi_bready) bvalid_d = 1'b0;

    if (wr_accept) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      case (lfsr_s_axi_awaddr)
        A_START: begin
          if (lfsr_s_axi_wdata[0] && fsm_q == ST_IDLE) begin
            lfsr_d   = (seed_q == '0) ? LFSR_W'(1) : seed_q;
            taps_w_d = taps_q;
            len_d    = count_q;
            cnt_d    = '0;
            done_d   = 1'b0;
            fsm_d    = ST_RUN;
          end
        end
        A_STOP: begin
          // A beat on the same edge already delivered the last word.
          if (lfsr_s_axi_wdata[0] && fsm_q == ST_RUN) begin
            fsm_d = beat ? ST_IDLE : ST_DRAIN;
          end
        end
        A_SEED:  seed_d  = lfsr_s_axi_wdata[LFSR_W-1:0];
        A_TAPS:  taps_d  = lfsr_s_axi_wdata[LFSR_W-1:0];
        A_COUNT: count_d = lfsr_s_axi_wdata;
        default: bresp_d = RESP_SLVERR;
      endcase
    end

    if (rvalid_q && lfsr_s_axi_rready) rvalid_d = 1'b0;

    if (rd_accept) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      case (lfsr_s_axi_araddr)
        A_START, A_STOP: rdata_d = '0;
        A_SEED:   rdata_d = 32'(seed_q);
        A_TAPS:   rdata_d = 32'(taps_q);
        A_COUNT:  rdata_d = count_q;
        A_STATUS: rdata_d = {29'd0, (fsm_q == ST_DRAIN), done_q, busy};
        A_STATE:  rdata_d = 32'(lfsr_q);
        default: begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      fsm_q     <= ST_IDLE;
      seed_q    <= RST_SEED;
      taps_q    <= RST_TAPS;
      count_q   <= '0;
      lfsr_q    <= RST_SEED;
      taps_w_q  <= RST_TAPS;
      len_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      fsm_q     <= fsm_d;
      seed_q    <= seed_d;
      taps_q    <= taps_d;
      count_q   <= count_d;
      lfsr_q    <= lfsr_d;
      taps_w_q  <= taps_w_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    lfsr_s_axi_awready = awready_q;
    lfsr_s_axi_wready  = wready_q;
    lfsr_s_axi_bvalid  = bvalid_q;
    lfsr_s_axi_bresp   = bresp_q;
    lfsr_s_axi_arready = arready_q;
    lfsr_s_axi_rvalid  = rvalid_q;
    lfsr_s_axi_rresp   = rresp_q;
    lfsr_s_axi_rdata   = rdata_q;
    lfsr_m_axis_tvalid = busy;
    lfsr_m_axis_tdata  = busy ? 32'(lfsr_q) : '0;
    lfsr_m_axis_tlast  = busy && last;
  end

endmodule

// File: tb/tb_lfsr_axil_gen.sv
// Testbench for lfsr_axil_gen (LFSR_W=8). Directed and randomized steps in
// one initial block, checked against a word-level reference model.
module tb_lfsr_axil_gen;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [4:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [4:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        tlast;

  always #5 aclk = ~aclk;

  lfsr_axil_gen #(
    .LFSR_W   (8),
    .RST_TAPS (8'hB8),
    .RST_SEED (8'h01)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .lfsr_s_axi_awaddr  (awaddr),
    .lfsr_s_axi_awvalid (awvalid),
    .lfsr_s_axi_awready (awready),
    .lfsr_s_axi_wdata   (wdata),
    .lfsr_s_axi_wvalid  (wvalid),
    .lfsr_s_axi_wready  (wready),
    .lfsr_s_axi_bresp   (bresp),
    .lfsr_s_axi_bvalid  (bvalid),
    .lfsr_s_axi_bready  (bready),
    .lfsr_s_axi_araddr  (araddr),
    .lfsr_s_axi_arvalid (arvalid),
    .lfsr_s_axi_arready (arready),
    .lfsr_s_axi_rdata   (rdata),
    .lfsr_s_axi_rresp   (rresp),
    .lfsr_s_axi_rvalid  (rvalid),
    .lfsr_s_axi_rready  (rready),
    .lfsr_m_axis_tdata  (tdata),
    .lfsr_m_axis_tvalid (tvalid),
    .lfsr_m_axis_tready (tready),
    .lfsr_m_axis_tlast  (tlast)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: software-visible registers plus the running job.
  logic [7:0]  m_seed, m_taps, m_state, m_tw;
  logic [31:0] m_count, m_len, m_cnt;
  bit          m_act, m_drain, m_done;
  logic        tvalid_at_accept;
  logic [7:0]  obs_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [7:0] t);
    int par;
    int nx;
    par = $countones(s & t) % 2;
    nx  = (int'(s) * 2 + par) % 256;
    return nx[7:0];
  endfunction

  task automatic model_reset();
    m_seed = 8'h01; m_taps = 8'hB8; m_count = 0;
    m_state = 8'h01; m_tw = 8'hB8; m_len = 0; m_cnt = 0;
    m_act = 0; m_drain = 0; m_done = 0;
  endtask

  function automatic bit model_last();
    return (m_len != 0) && (m_cnt == m_len - 1);
  endfunction

  task automatic model_beat();
    bit lst;
    lst = model_last();
    m_state = lfsr_next(m_state, m_tw);
    m_cnt = m_cnt + 1;
    if (lst) begin
      m_act = 0; m_drain = 0; m_done = 1;
    end else if (m_drain) begin
      m_act = 0; m_drain = 0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic axi_wr(input logic [4:0] a, input logic [31:0] d, output logic [1:0] resp);
    int k;
    bit got;
    got = 0; k = 0; resp = 2'bxx;
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    while (!got && k < 20) begin
      @(negedge aclk);
      if (awready === 1'b1) got = 1;
      else begin @(posedge aclk); #1; end
      k++;
    end
    chk("aw_handshake", {31'd0, got}, 32'd1);
    if (got) begin
      resp = bresp;
      tvalid_at_accept = tvalid;
      chk("wready_with_awready", {31'd0, wready}, 32'd1);
      chk("bvalid_on_accept", {31'd0, bvalid}, 32'd1);
    end
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0; bready = 1;
    @(posedge aclk); #1;
    bready = 0;
    chk("bvalid_clear", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic axi_rd(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int k;
    bit got;
    got = 0; k = 0; d = 'x; resp = 2'bxx;
    araddr = a; arvalid = 1;
    while (!got && k < 20) begin
      @(negedge aclk);
      if (arready === 1'b1) got = 1;
      else begin @(posedge aclk); #1; end
      k++;
    end
    chk("ar_handshake", {31'd0, got}, 32'd1);
    if (got) begin
      d = rdata; resp = rresp;
    end
    @(posedge aclk); #1;
    arvalid = 0;
    @(negedge aclk);
    chk("rdata_hold", rdata, d);
    @(posedge aclk); #1;
    rready = 1;
    @(posedge aclk); #1;
    rready = 0;
    chk("rvalid_clear", {31'd0, rvalid}, 32'd0);
  endtask

  // Register write, updating the model and checking bresp. tready is low.
  task automatic reg_wr(input logic [4:0] a, input logic [31:0] d);
    logic [1:0] r;
    logic [1:0] er;
    bit starting;
    er = 2'b00;
    starting = (a == 5'h00) && d[0] && !m_act;
    axi_wr(a, d, r);
    case (a)
      5'h00: if (starting) begin
        m_state = (m_seed == 0) ? 8'h01 : m_seed;
        m_tw = m_taps; m_len = m_count; m_cnt = 0;
        m_done = 0; m_drain = 0; m_act = 1;
        chk("start_latency", {31'd0, tvalid_at_accept}, 32'd1);
      end
      5'h04: if (d[0] && m_act && !m_drain) m_drain = 1;
      5'h08: m_seed = d[7:0];
      5'h0C: m_taps = d[7:0];
      5'h10: m_count = d;
      default: er = 2'b10;
    endcase
    chk("bresp", {30'd0, r}, {30'd0, er});
  endtask

  task automatic reg_rd(input logic [4:0] a, output logic [31:0] d);
    logic [1:0]  r;
    logic [31:0] ed;
    logic [1:0]  er;
    er = 2'b00;
    case (a)
      5'h00, 5'h04: ed = 0;
      5'h08: ed = {24'd0, m_seed};
      5'h0C: ed = {24'd0, m_taps};
      5'h10: ed = m_count;
      5'h14: ed = {29'd0, m_drain, m_done, m_act};
      5'h18: ed = {24'd0, m_state};
      default: begin ed = 0; er = 2'b10; end
    endcase
    axi_rd(a, d, r);
    chk($sformatf("rdata@%02h", a), d, ed);
    chk($sformatf("rresp@%02h", a), {30'd0, r}, {30'd0, er});
  endtask

  // mode: 0 tready=1, 1 toggle starting at 1, 2 random, 3 tready=0
  task automatic run(input int cycles, input int mode);
    for (int i = 0; i < cycles; i++) begin
      case (mode)
        0: tready = 1;
        1: tready = (i % 2 == 0);
        2: tready = $urandom_range(0, 1);
        default: tready = 0;
      endcase
      @(negedge aclk);
      chk("tvalid", {31'd0, tvalid}, {31'd0, m_act});
      if (m_act) begin
        chk("tdata", tdata, {24'd0, m_state});
        chk("tlast", {31'd0, tlast}, {31'd0, model_last()});
        if (tready) begin
          obs_q.push_back(tdata[7:0]);
          model_beat();
        end
      end else begin
        chk("tdata_idle", tdata, 32'd0);
        chk("tlast_idle", {31'd0, tlast}, 32'd0);
      end
      @(posedge aclk); #1;
    end
    tready = 0;
  endtask

  logic [31:0] rd;
  logic [7:0]  fr_exp[6];
  logic [7:0]  bu_exp[4];

  initial begin
    fr_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    bu_exp = '{8'h81, 8'h03, 8'h06, 8'h0C};
    model_reset();

    // Reset
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_tlast", {31'd0, tlast}, 32'd0);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    aresetn = 1;
    @(posedge aclk); #1;

    // Reset readback
    reg_rd(5'h08, rd); chk("rst_seed", rd, 32'h01);
    reg_rd(5'h0C, rd); chk("rst_taps", rd, 32'hB8);
    reg_rd(5'h10, rd); chk("rst_count", rd, 32'h0);
    reg_rd(5'h14, rd); chk("rst_status", rd, 32'h0);
    reg_rd(5'h18, rd);
    reg_rd(5'h1C, rd);
    reg_rd(5'h00, rd);
    reg_rd(5'h04, rd);

    // Free-run sequence
    reg_wr(5'h08, 32'h01);
    reg_wr(5'h0C, 32'hB8);
    reg_wr(5'h10, 32'h0);
    reg_wr(5'h00, 32'h1);
    obs_q.delete();
    run(6, 0);
    chk("fr_count", obs_q.size(), 32'd6);
    for (int i = 0; i < 6 && i < obs_q.size(); i++)
      chk($sformatf("fr_word%0d", i), {24'd0, obs_q[i]}, {24'd0, fr_exp[i]});

    // Stop under stall
    reg_rd(5'h18, rd);
    reg_wr(5'h04, 32'h1);
    reg_rd(5'h14, rd); chk("stop_status_drain", rd, 32'h5);
    run(3, 3);
    obs_q.delete();
    run(3, 0);
    chk("drain_beats", obs_q.size(), 32'd1);
    reg_rd(5'h14, rd); chk("stop_status_idle", rd, 32'h0);
    reg_wr(5'h04, 32'h1);

    // Burst with backpressure
    reg_wr(5'h08, 32'h81);
    reg_wr(5'h0C, 32'h80);
    reg_wr(5'h10, 32'h4);
    reg_wr(5'h00, 32'h1);
    obs_q.delete();
    run(12, 1);
    chk("burst_count", obs_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++)
      chk($sformatf("burst_word%0d", i), {24'd0, obs_q[i]}, {24'd0, bu_exp[i]});
    reg_rd(5'h14, rd); chk("burst_status", rd, 32'h2);

    // Randomized configurations
    for (int n = 0; n < 6; n++) begin
      reg_wr(5'h08, $urandom_range(0, 255));
      reg_wr(5'h0C, $urandom_range(1, 255));
      reg_wr(5'h10, $urandom_range(0, 9));
      reg_wr(5'h00, 32'h1);
      run(30, 2);
      reg_rd(5'h18, rd);
      if (m_act) begin
        reg_wr(5'h04, 32'h1);
        reg_rd(5'h14, rd);
        run(6, 2);
        run(2, 0);
      end
      reg_rd(5'h14, rd);
    end

    // Zero seed and live writes
    reg_wr(5'h08, 32'h0);
    reg_wr(5'h0C, 32'hB8);
    reg_wr(5'h10, 32'h0);
    reg_wr(5'h00, 32'h1);
    obs_q.delete();
    run(1, 0);
    chk("zero_seed_first", obs_q.size() > 0 ? {24'd0, obs_q[0]} : 32'hFFFF_FFFF, 32'h01);
    run(4, 0);
    reg_wr(5'h0C, 32'h80);
    run(10, 2);
    reg_wr(5'h14, 32'h1);
    reg_wr(5'h18, 32'h55);
    reg_wr(5'h1C, 32'h1);
    reg_wr(5'h00, 32'h1);
    run(4, 0);
    reg_rd(5'h18, rd);
    reg_rd(5'h0C, rd); chk("live_taps", rd, 32'h80);
    reg_wr(5'h04, 32'h1);
    run(3, 0);

    // Reset mid-burst
    reg_wr(5'h08, 32'h5A);
    reg_wr(5'h10, 32'd20);
    reg_wr(5'h00, 32'h1);
    run(5, 0);
    aresetn = 0; tready = 1;
    @(posedge aclk); #1;
    aresetn = 1; tready = 0;
    model_reset();
    @(negedge aclk);
    chk("mid_rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("mid_rst_tdata", tdata, 32'd0);
    @(posedge aclk); #1;
    reg_rd(5'h18, rd); chk("mid_rst_state", rd, 32'h01);
    reg_rd(5'h0C, rd); chk("mid_rst_taps", rd, 32'hB8);
    reg_rd(5'h14, rd); chk("mid_rst_status", rd, 32'h0);
    reg_rd(5'h10, rd);
    run(3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lfsr_axil_gen.md
# lfsr_axil_gen

Parametrised successor to the 8-bit AXI-Lite-configured LFSR core. It generates a Fibonacci LFSR sequence of configurable width on an AXI-Stream master with full `tready` backpressure. It adds a burst mode (N words then `tlast` and auto-stop), seed-zero protection, and status/state readback. Software configures it over AXI-Lite. It sits between the control processor's AXI-Lite bus and downstream stream consumers (histogram, RAM writer).

## Interface
- `LFSR_W`, 8: LFSR width, 2..32.
- `RST_TAPS`, 8'hB8: reset value of TAPS, `LFSR_W` bits.
- `RST_SEED`, 1: reset value of SEED, `LFSR_W` bits.

Ports (all AXI-Lite data is 32 bits):
- `aclk` in 1: the single clock, all logic on the rising edge.
- `aresetn` in 1: reset, synchronous and active-low.
- `lfsr_s_axi_awaddr` in 5, `lfsr_s_axi_awvalid` in 1, `lfsr_s_axi_awready` out 1: write address channel.
- `lfsr_s_axi_wdata` in 32, `lfsr_s_axi_wvalid` in 1, `lfsr_s_axi_wready` out 1: write data channel.
- `lfsr_s_axi_bresp` out 2, `lfsr_s_axi_bvalid` out 1, `lfsr_s_axi_bready` in 1: write response channel.
- `lfsr_s_axi_araddr` in 5, `lfsr_s_axi_arvalid` in 1, `lfsr_s_axi_arready` out 1: read address channel.
- `lfsr_s_axi_rdata` out 32, `lfsr_s_axi_rresp` out 2, `lfsr_s_axi_rvalid` out 1, `lfsr_s_axi_rready` in 1: read data channel.
- `lfsr_m_axis_tdata` out 32: current state, zero-extended from `LFSR_W`.
- `lfsr_m_axis_tvalid` out 1, `lfsr_m_axis_tready` in 1, `lfsr_m_axis_tlast` out 1: output stream.

## Operation
Register map (byte address, 32-bit):
- 0x00 START (WO): write with bit0=1 → start if IDLE; otherwise ignored.
- 0x04 STOP (WO): write with bit0=1 → stop request.
- 0x08 SEED (RW, `LFSR_W` bits).
- 0x0C TAPS (RW, `LFSR_W` bits).
- 0x10 COUNT (RW, 32 bits): burst length; 0 = free-run.
- 0x14 STATUS (RO): bit0 running (RUN or DRAIN), bit1 done (sticky), bit2 drain.
- 0x18 STATE (RO): working LFSR state.
- Reads of WO registers return 0 with OKAY.
- Unmapped address, or write to RO: SLVERR (2'b10), no side effect. Otherwise OKAY (2'b00).

LFSR step:
- `fb = ^(state & taps_w)`.
- `state_next = {state[LFSR_W-2:0], fb}`.

Start, commit at the write handshake edge:
- Working copies load: `state` ← SEED (or 1 if SEED==0), `taps_w` ← TAPS, `len` ← COUNT.
- Beat counter ← 0, done ← 0, FSM → RUN.
- SEED/TAPS/COUNT writes during a run affect only the next start.

FSM states IDLE, RUN, DRAIN:
- **IDLE:** `tvalid`=0.
- **RUN/DRAIN:** `tvalid`=1, `tdata`=state.
- **Each beat** (`tvalid & tready` edge): state ← `state_next`, counter +1.
- **RUN, burst end:** beat with counter==`len`-1 (`len`≠0) → IDLE, done ← 1. `tlast`=1 during that beat only; `tlast`=0 always when `len`=0.
- **RUN, STOP commit:** if a beat occurs on the same edge → IDLE; else → DRAIN.
- **DRAIN:** next beat → IDLE. `tlast` keeps its burst meaning. `tvalid` never drops without a handshake.
- **STOP in IDLE:** no effect, OKAY.
- **Counter:** 32-bit, wraps silently in free-run.

## Timing
- **Reset values:** every output 0. SEED=`RST_SEED`, TAPS=`RST_TAPS`, COUNT=0, STATUS=0, state=`RST_SEED`, FSM IDLE.
- **Reset mid-operation:** outputs return to reset values on the next edge; in-flight AXI transactions are dropped.
- **Write address/data:**
  - When `awvalid & wvalid & !bvalid & !awready`, `awready` and `wready` go high together for exactly one cycle (registered).
  - The write commits on that edge, and `bvalid` rises on it.
  - `bvalid` holds until the `bready` edge. No new write is accepted while `bvalid`=1.
- **Read address/data:**
  - When `arvalid & !rvalid & !arready`, `arready` pulses for one cycle.
  - `rdata`/`rresp` are captured and `rvalid` set on that edge.
  - `rvalid` holds, with data stable, until the `rready` edge.
- **Start latency:** `tvalid`=1 in the first cycle after the START commit edge.
- **Throughput:** one word per cycle when `tready`=1. With `tready`=0, `tdata`/`tlast` stay stable.
- **Stop latency:** `tvalid` falls the cycle after the final beat.
- **Simultaneous events:** a read and a write may be in flight concurrently and are independent. STATE read on a beat edge returns the pre-beat value.

## Test plan
- **Reset readback:** after reset, read 0x08/0x0C/0x10/0x14 → 0x01, 0xB8, 0x0, 0x0. Read 0x1C → rresp=2'b10.
- **Free-run sequence:** `LFSR_W`=8, SEED=0x01, TAPS=0xB8, COUNT=0, START, `tready`=1 → `tdata` 0x01, 0x02, 0x04, 0x08, 0x11, 0x23 on consecutive cycles; `tlast`=0.
- **Burst with backpressure:** SEED=0x81, TAPS=0x80, COUNT=4, `tready` toggling 1/0 → beats 0x81, 0x03, 0x06, 0x0C; `tlast` on 0x0C only; data stable while `tready`=0; then `tvalid`=0 and STATUS=0x2.
- **Stop under stall:** free-run, hold `tready`=0, write STOP → STATUS=0x5 and `tvalid` stays 1; raise `tready` → one more beat, then `tvalid`=0 and STATUS=0x0.
- **Zero seed and live writes:** SEED=0, START → first beat 0x01. Write TAPS=0x80 mid-run → sequence unchanged until the next start. Write 0x14 → bresp=2'b10.
- **Reset mid-burst:** `aresetn`=0 for one edge during RUN → next cycle `tvalid`=0, STATE=0x01, TAPS=0xB8.
